scalar_mult_ctrl: RTL

- Sequencer that computes the scalar point multiplication Q = k·P on the Ed25519 curve.
- Drives a single shared point-addition unit (projective X/Y/Z, 256-bit coordinates) with a left-to-right double-and-add schedule.
- A doubling is issued as an addition of R with itself.
- Sits between the top-level signature/key FSM and the point-add datapath.
- Treats point-add as a black box with a start/finished handshake; it never touches field arithmetic itself.

---
 rtl/scalar_mult_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl: left-to-right double-and-add sequencer for Q = k*P on
// Ed25519. It drives one shared projective point-add unit and does no field
// arithmetic itself. A doubling is issued as R + R.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             request pulse, sampled only in IDLE
//   i_scalar            scalar k, latched on an accepted start
//   i_px/i_py/i_pz      base point P, latched on an accepted start
//   o_busy              high from the cycle after acceptance until o_done
//   o_done              one-cycle completion pulse
//   o_qx/o_qy/o_qz      result Q, valid from o_done until the next o_done
//   o_pa_start          one-cycle start pulse to the point-add unit
//   o_pa_{x,y,z}1       operand 1 (always R)
//   o_pa_{x,y,z}2       operand 2 (R for doubling, P for adding)
//   i_pa_{x,y,z}3       point-add result
//   i_pa_finished       point-add one-cycle done pulse
//
// Build option: define SCALAR_MULT_CONST_TIME_EN to issue an add for every
// scalar bit (result kept only when the bit is 1), making timing independent
// of k.
module scalar_mult_ctrl #(
  parameter int           SCALAR_W = 256,
  parameter logic [255:0] ID_X     = 256'd0,
  parameter logic [255:0] ID_Y     = 256'd1,
  parameter logic [255:0] ID_Z     = 256'd1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [SCALAR_W-1:0] i_scalar,
  input  logic [255:0]        i_px,
  input  logic [255:0]        i_py,
  input  logic [255:0]        i_pz,
  output logic                o_busy,
  output logic                o_done,
  output logic [255:0]        o_qx,
  output logic [255:0]        o_qy,
  output logic [255:0]        o_qz,
  output logic                o_pa_start,
  output logic [255:0]        o_pa_x1,
  output logic [255:0]        o_pa_y1,
  output logic [255:0]        o_pa_z1,
  output logic [255:0]        o_pa_x2,
  output logic [255:0]        o_pa_y2,
  output logic [255:0]        o_pa_z2,
  input  logic [255:0]        i_pa_x3,
  input  logic [255:0]        i_pa_y3,
  input  logic [255:0]        i_pa_z3,
  input  logic                i_pa_finished
);

  localparam int IDX_W = (SCALAR_W > 1) ? $clog2(SCALAR_W) : 1;

`ifdef SCALAR_MULT_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, NEXT, DONE
  } state_t;

  state_t              state, state_nx;
  logic [255:0]        r_x, r_y, r_z;
  logic [255:0]        p_x, p_y, p_z;
  logic [SCALAR_W-1:0] k;
  logic [IDX_W-1:0]    idx;
  logic                add_pending;   // current bit's add result must be kept
  logic                kbit;
  logic                do_add;

  assign kbit   = k[idx];
  assign do_add = CONST_TIME || kbit;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (i_start) state_nx = DBL_REQ;
      DBL_REQ:  state_nx = DBL_WAIT;
      DBL_WAIT: if (i_pa_finished) state_nx = do_add ? ADD_REQ : NEXT;
      ADD_REQ:  state_nx = ADD_WAIT;
      ADD_WAIT: if (i_pa_finished) state_nx = NEXT;
      NEXT:     state_nx = (idx == '0) ? DONE : DBL_REQ;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      p_x         <= '0;
      p_y         <= '0;
      p_z         <= '0;
      k           <= '0;
      idx         <= '0;
      add_pending <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_qx        <= '0;
      o_qy        <= '0;
      o_qz        <= '0;
      o_pa_start  <= 1'b0;
      o_pa_x1     <= '0;
      o_pa_y1     <= '0;
      o_pa_z1     <= '0;
      o_pa_x2     <= '0;
      o_pa_y2     <= '0;
      o_pa_z2     <= '0;
    end else begin
      state      <= state_nx;
      // Start is registered so it lines up with the REQ state cycle; the
      // operands are loaded on the same edge, from R's next value.
      o_pa_start <= (state_nx == DBL_REQ) || (state_nx == ADD_REQ);
      o_done     <= 1'b0;
      unique case (state)
        IDLE: if (i_start) begin
          p_x         <= i_px;
          p_y         <= i_py;
          p_z         <= i_pz;
          k           <= i_scalar;
          r_x         <= ID_X;
          r_y         <= ID_Y;
          r_z         <= ID_Z;
          idx         <= IDX_W'(SCALAR_W - 1);
          add_pending <= 1'b0;
          o_busy      <= 1'b1;
          o_pa_x1     <= ID_X;
          o_pa_y1     <= ID_Y;
          o_pa_z1     <= ID_Z;
          o_pa_x2     <= ID_X;
          o_pa_y2     <= ID_Y;
          o_pa_z2     <= ID_Z;
        end
        DBL_WAIT: if (i_pa_finished) begin
          r_x         <= i_pa_x3;
          r_y         <= i_pa_y3;
          r_z         <= i_pa_z3;
          add_pending <= kbit;
          if (do_add) begin
            o_pa_x1 <= i_pa_x3;
            o_pa_y1 <= i_pa_y3;
            o_pa_z1 <= i_pa_z3;
            o_pa_x2 <= p_x;
            o_pa_y2 <= p_y;
            o_pa_z2 <= p_z;
          end
        end
        // In constant-time mode a zero bit still runs the add; its result
        // is dropped here.
        ADD_WAIT: if (i_pa_finished && add_pending) begin
          r_x <= i_pa_x3;
          r_y <= i_pa_y3;
          r_z <= i_pa_z3;
        end
        NEXT: if (idx != '0) begin
          idx     <= idx - 1'b1;
          o_pa_x1 <= r_x;
          o_pa_y1 <= r_y;
          o_pa_z1 <= r_z;
          o_pa_x2 <= r_x;
          o_pa_y2 <= r_y;
          o_pa_z2 <= r_z;
        end
        DONE: begin
          o_qx   <= r_x;
          o_qy   <= r_y;
          o_qz   <= r_z;
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
